// File: rtl/cache_fill_ctrl.sv
// Miss-fill engine: victim lookup, line fetch in beats, single-cycle
// write of tag and assembled line into the cache arrays.
module cache_fill_ctrl #(
   parameter int NUM_WAYS         = 4,
   parameter int NUM_SETS         = 16,
   parameter int CACHE_TAG_WIDTH  = 22,
   parameter int CACHE_LINE_BYTES = 64,
   parameter int MEM_BEAT_BYTES   = 16,
   localparam int NUM_WAYS_LOG    = $clog2(NUM_WAYS),
   localparam int NUM_SETS_LOG    = $clog2(NUM_SETS),
   localparam int CACHE_LINE_BITS = 8 * CACHE_LINE_BYTES,
   localparam int MEM_BEAT_BITS   = 8 * MEM_BEAT_BYTES,
   localparam int NUM_BEATS       = CACHE_LINE_BYTES / MEM_BEAT_BYTES
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    miss_valid,
   output logic                                    miss_ready,
   input  logic [NUM_SETS_LOG-1:0]                 miss_set_idx,
   input  logic [CACHE_TAG_WIDTH-1:0]              miss_tag,
   output logic                                    lru_fill_en,
   output logic [NUM_SETS_LOG-1:0]                 lru_fill_set,
   input  logic [NUM_WAYS_LOG-1:0]                 lru_fill_way_idx,
   output logic                                    mem_req_valid,
   input  logic                                    mem_req_ready,
   output logic [CACHE_TAG_WIDTH+NUM_SETS_LOG-1:0] mem_req_addr,
   input  logic                                    mem_resp_valid,
   output logic                                    mem_resp_ready,
   input  logic [MEM_BEAT_BITS-1:0]                mem_resp_data,
   output logic                                    update_tag_en,
   output logic [NUM_WAYS_LOG-1:0]                 update_tag_way_idx,
   output logic [NUM_SETS_LOG-1:0]                 update_tag_set_idx,
   output logic [CACHE_TAG_WIDTH-1:0]              update_tag,
   output logic                                    update_tag_valid,
   output logic                                    update_data_en,
   output logic [NUM_WAYS_LOG-1:0]                 update_data_way_idx,
   output logic [NUM_SETS_LOG-1:0]                 update_data_set_idx,
   output logic [CACHE_LINE_BITS-1:0]              update_data,
   output logic                                    fill_done,
   output logic [NUM_WAYS_LOG-1:0]                 fill_way_idx
);

   localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LRU   = 3'd1;
   localparam logic [2:0] REQ   = 3'd2;
   localparam logic [2:0] RECV  = 3'd3;
   localparam logic [2:0] WRITE = 3'd4;

   logic [2:0]                 state_q;
   logic [2:0]                 state_d;
   logic [NUM_SETS_LOG-1:0]    set_q;
   logic [CACHE_TAG_WIDTH-1:0] tag_q;
   logic [NUM_WAYS_LOG-1:0]    way_q;
   logic [CACHE_LINE_BITS-1:0] line_q;
   logic [CNT_W-1:0]           cnt_q;
   logic                       first_q;

   logic st_idle;
   logic st_lru;
   logic st_req;
   logic st_recv;
   logic st_write;
   logic last_beat;

   assign st_idle   = (state_q == IDLE);
   assign st_lru    = (state_q == LRU);
   assign st_req    = (state_q == REQ);
   assign st_recv   = (state_q == RECV);
   assign st_write  = (state_q == WRITE);
   assign last_beat = (cnt_q == CNT_W'(NUM_BEATS - 1));

   always_comb begin
      state_d = IDLE;
      unique case (1'b1)
         st_idle:  state_d = miss_valid ? LRU : IDLE;
         st_lru:   state_d = REQ;
         st_req:   state_d = mem_req_ready ? RECV : REQ;
         st_recv:  state_d = (mem_resp_valid && last_beat) ? WRITE : RECV;
         st_write: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_q <= '0;
         tag_q <= '0;
      end else if (st_idle && miss_valid) begin
         set_q <= miss_set_idx;
         tag_q <= miss_tag;
      end
   end

   // LRU answers one cycle after the query, i.e. in the first REQ cycle only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q <= 1'b0;
         way_q   <= '0;
      end else begin
         first_q <= st_lru;
         if (st_req && first_q) begin
            way_q <= lru_fill_way_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (st_req && mem_req_ready) begin
         cnt_q <= '0;
      end else if (st_recv && mem_resp_valid) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
      end else if (st_recv && mem_resp_valid) begin
         for (int b = 0; b < NUM_BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
               line_q[b*MEM_BEAT_BITS +: MEM_BEAT_BITS] <= mem_resp_data;
            end
         end
      end
   end

   assign miss_ready     = st_idle;
   assign lru_fill_en    = st_lru;
   assign lru_fill_set   = set_q;
   assign mem_req_valid  = st_req;
   assign mem_req_addr   = {tag_q, set_q};
   assign mem_resp_ready = st_recv;

   assign update_tag_en       = st_write;
   assign update_tag_valid    = st_write;
   assign update_tag_way_idx  = way_q;
   assign update_tag_set_idx  = set_q;
   assign update_tag          = tag_q;
   assign update_data_en      = st_write;
   assign update_data_way_idx = way_q;
   assign update_data_set_idx = set_q;
   assign update_data         = line_q;
   assign fill_done           = st_write;
   assign fill_way_idx        = way_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: vector table driven through a fill task,
// scoreboard checked on each array write, plus 1- and 16-beat instances.
module tb_cache_fill_ctrl;

   localparam int BW = 128;
   localparam int NB = 4;
   localparam int LB = 512;

   typedef struct {
      logic [3:0]  set;
      logic [21:0] tag;
      logic [1:0]  way;
      int          stall;
      bit          gaps;
      bit          hold;
      int          abort;
      bit          fixed;
      logic [25:0] exp_addr;
   } vec_t;

   typedef struct {
      logic [3:0]    set;
      logic [21:0]   tag;
      logic [1:0]    way;
      logic [LB-1:0] line;
      int            lat;
      int            t_acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;
   int n_wr = 0;
   int n_lru = 0;
   exp_t sb[$];
   exp_t me;

   logic          miss_valid = 1'b0;
   logic          miss_ready;
   logic [3:0]    miss_set_idx = '0;
   logic [21:0]   miss_tag = '0;
   logic          lru_fill_en;
   logic [3:0]    lru_fill_set;
   logic [1:0]    lru_fill_way_idx = '0;
   logic          mem_req_valid;
   logic          mem_req_ready = 1'b0;
   logic [25:0]   mem_req_addr;
   logic          mem_resp_valid = 1'b0;
   logic          mem_resp_ready;
   logic [BW-1:0] mem_resp_data = '0;
   logic          update_tag_en;
   logic [1:0]    update_tag_way_idx;
   logic [3:0]    update_tag_set_idx;
   logic [21:0]   update_tag;
   logic          update_tag_valid;
   logic          update_data_en;
   logic [1:0]    update_data_way_idx;
   logic [3:0]    update_data_set_idx;
   logic [LB-1:0] update_data;
   logic          fill_done;
   logic [1:0]    fill_way_idx;

   cache_fill_ctrl u_dut (
      .clk(clk), .rst_n(rst_n),
      .miss_valid(miss_valid), .miss_ready(miss_ready),
      .miss_set_idx(miss_set_idx), .miss_tag(miss_tag),
      .lru_fill_en(lru_fill_en), .lru_fill_set(lru_fill_set),
      .lru_fill_way_idx(lru_fill_way_idx),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
      .mem_resp_data(mem_resp_data),
      .update_tag_en(update_tag_en),
      .update_tag_way_idx(update_tag_way_idx),
      .update_tag_set_idx(update_tag_set_idx),
      .update_tag(update_tag), .update_tag_valid(update_tag_valid),
      .update_data_en(update_data_en),
      .update_data_way_idx(update_data_way_idx),
      .update_data_set_idx(update_data_set_idx),
      .update_data(update_data),
      .fill_done(fill_done), .fill_way_idx(fill_way_idx)
   );

   // shared stimulus for the 1-beat and 16-beat instances
   logic        sw_valid = 1'b0;
   logic [3:0]  sw_set = 4'hC;
   logic [21:0] sw_tag = 22'h1F0F0F;
   logic [1:0]  sw_way = 2'd1;
   logic        sw_one = 1'b1;
   int          t_sw = 0;
   bit          s1_done = 0;
   bit          s16_done = 0;
   int          s1_k = 0;
   int          s16_k = 0;
   logic [LB-1:0] exp16;

   logic          s1_miss_ready, s1_lru_fill_en, s1_mem_req_valid;
   logic [3:0]    s1_lru_fill_set;
   logic [25:0]   s1_mem_req_addr;
   logic          s1_mem_resp_ready;
   logic [LB-1:0] s1_mem_resp_data;
   logic          s1_update_tag_en, s1_update_tag_valid, s1_update_data_en;
   logic [1:0]    s1_update_tag_way_idx, s1_update_data_way_idx;
   logic [3:0]    s1_update_tag_set_idx, s1_update_data_set_idx;
   logic [21:0]   s1_update_tag;
   logic [LB-1:0] s1_update_data;
   logic          s1_fill_done;
   logic [1:0]    s1_fill_way_idx;

   logic          s16_miss_ready, s16_lru_fill_en, s16_mem_req_valid;
   logic [3:0]    s16_lru_fill_set;
   logic [25:0]   s16_mem_req_addr;
   logic          s16_mem_resp_ready;
   logic [31:0]   s16_mem_resp_data;
   logic          s16_update_tag_en, s16_update_tag_valid, s16_update_data_en;
   logic [1:0]    s16_update_tag_way_idx, s16_update_data_way_idx;
   logic [3:0]    s16_update_tag_set_idx, s16_update_data_set_idx;
   logic [21:0]   s16_update_tag;
   logic [LB-1:0] s16_update_data;
   logic          s16_fill_done;
   logic [1:0]    s16_fill_way_idx;

   function automatic logic [31:0] pat32(input int k);
      return {8'(k), 8'hA5, 8'(k * 3), 8'h5A};
   endfunction

   assign s1_mem_resp_data  = {16{pat32(s1_k)}};
   assign s16_mem_resp_data = pat32(s16_k);

   cache_fill_ctrl #(.MEM_BEAT_BYTES(64)) u_b1 (
      .clk(clk), .rst_n(rst_n),
      .miss_valid(sw_valid), .miss_ready(s1_miss_ready),
      .miss_set_idx(sw_set), .miss_tag(sw_tag),
      .lru_fill_en(s1_lru_fill_en), .lru_fill_set(s1_lru_fill_set),
      .lru_fill_way_idx(sw_way),
      .mem_req_valid(s1_mem_req_valid), .mem_req_ready(sw_one),
      .mem_req_addr(s1_mem_req_addr),
      .mem_resp_valid(sw_one), .mem_resp_ready(s1_mem_resp_ready),
      .mem_resp_data(s1_mem_resp_data),
      .update_tag_en(s1_update_tag_en),
      .update_tag_way_idx(s1_update_tag_way_idx),
      .update_tag_set_idx(s1_update_tag_set_idx),
      .update_tag(s1_update_tag), .update_tag_valid(s1_update_tag_valid),
      .update_data_en(s1_update_data_en),
      .update_data_way_idx(s1_update_data_way_idx),
      .update_data_set_idx(s1_update_data_set_idx),
      .update_data(s1_update_data),
      .fill_done(s1_fill_done), .fill_way_idx(s1_fill_way_idx)
   );

   cache_fill_ctrl #(.MEM_BEAT_BYTES(4)) u_b16 (
      .clk(clk), .rst_n(rst_n),
      .miss_valid(sw_valid), .miss_ready(s16_miss_ready),
      .miss_set_idx(sw_set), .miss_tag(sw_tag),
      .lru_fill_en(s16_lru_fill_en), .lru_fill_set(s16_lru_fill_set),
      .lru_fill_way_idx(sw_way),
      .mem_req_valid(s16_mem_req_valid), .mem_req_ready(sw_one),
      .mem_req_addr(s16_mem_req_addr),
      .mem_resp_valid(sw_one), .mem_resp_ready(s16_mem_resp_ready),
      .mem_resp_data(s16_mem_resp_data),
      .update_tag_en(s16_update_tag_en),
      .update_tag_way_idx(s16_update_tag_way_idx),
      .update_tag_set_idx(s16_update_tag_set_idx),
      .update_tag(s16_update_tag), .update_tag_valid(s16_update_tag_valid),
      .update_data_en(s16_update_data_en),
      .update_data_way_idx(s16_update_data_way_idx),
      .update_data_set_idx(s16_update_data_set_idx),
      .update_data(s16_update_data),
      .fill_done(s16_fill_done), .fill_way_idx(s16_fill_way_idx)
   );

   // memory model for the sweep: advance to the next beat on each accepted beat
   always @(posedge clk) begin
      if (s1_mem_resp_ready) s1_k <= s1_k + 1;
      if (s16_mem_resp_ready) s16_k <= s16_k + 1;
   end

   task automatic chk(input string nm, input logic [LB-1:0] act,
                      input logic [LB-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_rst(input string nm);
      chk({nm, "_flags"},
          {miss_ready, lru_fill_en, mem_req_valid, mem_resp_ready,
           update_tag_en, update_data_en, update_tag_valid, fill_done},
          8'h80);
      chk({nm, "_idx"},
          {lru_fill_set, mem_req_addr, update_tag_way_idx,
           update_data_way_idx, update_tag_set_idx, update_data_set_idx,
           update_tag, fill_way_idx}, '0);
      chk({nm, "_data"}, update_data, '0);
   endtask

   always @(negedge clk) begin
      if (lru_fill_en) n_lru++;
      if (update_tag_en || update_data_en || fill_done) begin
         n_wr++;
         if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_write: got write at cycle %0d want none", cyc);
         end else begin
            me = sb.pop_front();
            chk("wr_strobes",
                {update_tag_en, update_data_en, update_tag_valid, fill_done},
                4'hF);
            chk("wr_set", {update_tag_set_idx, update_data_set_idx},
                {me.set, me.set});
            chk("wr_way",
                {update_tag_way_idx, update_data_way_idx, fill_way_idx},
                {me.way, me.way, me.way});
            chk("wr_tag", update_tag, me.tag);
            chk("wr_line", update_data, me.line);
            chk("latency", cyc - me.t_acc + 1, me.lat);
         end
      end
      if (s1_fill_done) begin
         s1_done = 1;
         chk("sw1_line", s1_update_data, {16{pat32(0)}});
         chk("sw1_way", s1_fill_way_idx, 2'd1);
         chk("sw1_lat", cyc - t_sw + 1, 4);
      end
      if (s16_fill_done) begin
         s16_done = 1;
         chk("sw16_line", s16_update_data, exp16);
         chk("sw16_tag", {s16_update_tag, s16_update_tag_set_idx},
             {22'h1F0F0F, 4'hC});
         chk("sw16_lat", cyc - t_sw + 1, 19);
      end
   end

   task automatic run_fill(input vec_t v, input vec_t nx);
      logic [BW-1:0] beats [NB];
      int            gap [NB];
      exp_t          e;
      int            lru0;
      int            nw0;
      logic [7:0]    b8;
      e.lat = 3 + NB + v.stall;
      for (int k = 0; k < NB; k++) begin
         b8 = 8'h11 * 8'(k + 1);
         beats[k] = v.fixed ? {16{b8}} : {$urandom, $urandom, $urandom, $urandom};
         gap[k] = v.gaps ? $urandom_range(0, 2) : 0;
         e.lat += gap[k];
         e.line[k*BW +: BW] = beats[k];
      end
      e.set = v.set;
      e.tag = v.tag;
      e.way = v.way;
      for (int w = 0; w < 20 && !miss_ready; w++) begin
         @(posedge clk);
         #1;
      end
      chk("miss_ready_wait", miss_ready, 1'b1);
      if (!miss_ready) return;
      miss_valid = 1'b1;
      miss_set_idx = v.set;
      miss_tag = v.tag;
      lru0 = n_lru;
      @(posedge clk);
      #1;
      e.t_acc = cyc;
      sb.push_back(e);
      if (v.hold) begin
         miss_set_idx = nx.set;
         miss_tag = nx.tag;
      end else begin
         miss_valid = 1'b0;
      end
      lru_fill_way_idx = v.way;
      mem_resp_valid = 1'b1;
      mem_resp_data = '1;
      mem_req_ready = (v.stall == 0);
      @(negedge clk);
      chk("lru_cycle", {lru_fill_en, lru_fill_set, miss_ready, mem_req_valid},
          {1'b1, v.set, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      for (int i = 0; i <= v.stall; i++) begin
         @(negedge clk);
         chk("req_cycle",
             {mem_req_valid, mem_req_addr, lru_fill_en, mem_resp_ready, miss_ready},
             {1'b1, v.exp_addr, 3'b000});
         @(posedge clk);
         #1;
         lru_fill_way_idx = ~v.way;
         mem_req_ready = (i + 1 == v.stall);
      end
      for (int k = 0; k < NB; k++) begin
         if (k == v.abort) begin
            nw0 = n_wr;
            rst_n = 1'b0;
            mem_resp_valid = 1'b1;
            #1;
            chk_rst("mid_rst");
            void'(sb.pop_back());
            repeat (3) @(posedge clk);
            #1;
            chk_rst("held_rst");
            rst_n = 1'b1;
            mem_resp_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("no_write_after_rst", n_wr - nw0, 0);
            return;
         end
         mem_resp_valid = 1'b0;
         for (int g = 0; g < gap[k]; g++) begin
            @(negedge clk);
            chk("recv_gap", {mem_resp_ready, miss_ready, update_data_en}, 3'b100);
            @(posedge clk);
            #1;
         end
         mem_resp_valid = 1'b1;
         mem_resp_data = beats[k];
         @(negedge clk);
         chk("recv_beat", {mem_resp_ready, miss_ready, update_data_en}, 3'b100);
         @(posedge clk);
         #1;
      end
      mem_resp_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_fill", miss_ready, 1'b1);
      chk("lru_once", n_lru - lru0, 1);
      chk("sb_drained", sb.size(), 0);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{set:4'h5, tag:22'h2A5A5A, way:2'd2, stall:0, gaps:0,
                  hold:0, abort:-1, fixed:1, exp_addr:26'h2A5A5A5};
      vecs[1] = '{set:4'h3, tag:22'h3FFFFF, way:2'd1, stall:5, gaps:0,
                  hold:0, abort:-1, fixed:0, exp_addr:26'h3FFFFF3};
      vecs[2] = '{set:4'hF, tag:22'h000000, way:2'd3, stall:2, gaps:1,
                  hold:0, abort:-1, fixed:0, exp_addr:26'h000000F};
      vecs[3] = '{set:4'h0, tag:22'h155555, way:2'd0, stall:0, gaps:0,
                  hold:1, abort:-1, fixed:0, exp_addr:26'h1555550};
      vecs[4] = '{set:4'hA, tag:22'h0ABCDE, way:2'd1, stall:1, gaps:1,
                  hold:0, abort:-1, fixed:0, exp_addr:26'h0ABCDEA};
      vecs[5] = '{set:4'h7, tag:22'h012345, way:2'd2, stall:0, gaps:0,
                  hold:0, abort:2, fixed:0, exp_addr:26'h0123457};
      vecs[6] = '{set:4'h9, tag:22'h2FEDCB, way:2'd3, stall:0, gaps:1,
                  hold:0, abort:-1, fixed:0, exp_addr:26'h2FEDCB9};
      for (int k = 0; k < 16; k++) exp16[k*32 +: 32] = pat32(k);

      repeat (3) @(posedge clk);
      #1;
      chk_rst("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         run_fill(vecs[i], vecs[(i + 1) % 7]);
      end

      chk("sweep_idle", {s1_miss_ready, s16_miss_ready}, 2'b11);
      sw_valid = 1'b1;
      @(posedge clk);
      #1;
      t_sw = cyc;
      sw_valid = 1'b0;
      for (int i = 0; i < 40 && !(s1_done && s16_done); i++) @(posedge clk);
      #1;
      chk("sweep_done", {s1_done, s16_done}, 2'b11);
      chk("final_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout at cycle %0d want completion", cyc);
      $fatal(1);
   end

endmodule
